// File: rtl/pipelined_cla_addsub.sv
// ============================================================================
// Module   : pipelined_cla_addsub
// Brief    : Parametrised pipelined two-level CLA adder/subtractor with signed
//            saturation, sticky overflow and valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overFlow,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;
  localparam int LAST = STAGES - 1;

  logic             w_adv;
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_sat [STAGES];

  logic [WIDTH-1:0] w_acc  [STAGES];
  logic             w_cout [STAGES];
  logic             w_cmsb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_S;
  logic             r_cout;
  logic             r_ovf;
  logic             r_sticky;

  assign w_adv      = !r_out_valid || out_ready;
  assign in_ready   = w_adv;
  assign out_valid  = r_out_valid;
  assign S          = r_S;
  assign Cout       = r_cout;
  assign overFlow   = r_ovf;
  assign ovf_sticky = r_sticky;

  // Segment k adds its slice of rank k and merges it into the partial sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    localparam int OFF = k * SEG;
    logic [SEG-1:0]   w_p;
    logic [SEG-1:0]   w_g;
    logic [SEG-1:0]   w_c;
    logic [NGRP-1:0]  w_gg;
    logic [NGRP-1:0]  w_gp;
    logic [NGRP:0]    w_gc;
    logic [WIDTH-1:0] w_merged;
    logic             w_term;

    always_comb begin
      w_term = 1'b0;
      w_p    = r_a[k][OFF +: SEG] ^ r_b[k][OFF +: SEG];
      w_g    = r_a[k][OFF +: SEG] & r_b[k][OFF +: SEG];
      for (int j = 0; j < NGRP; j++) begin
        w_gg[j] = 1'b0;
        w_gp[j] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
          w_gg[j] = w_g[j*BLOCK+i] | (w_p[j*BLOCK+i] & w_gg[j]);
          w_gp[j] = w_gp[j] & w_p[j*BLOCK+i];
        end
      end
      // Flattened group-level lookahead: each group carry is a sum of products.
      for (int j = 0; j <= NGRP; j++) begin
        w_gc[j] = r_c[k];
        for (int i = 0; i < j; i++) begin
          w_gc[j] = w_gc[j] & w_gp[i];
        end
        for (int i = 0; i < j; i++) begin
          w_term = w_gg[i];
          for (int m = i + 1; m < j; m++) begin
            w_term = w_term & w_gp[m];
          end
          w_gc[j] = w_gc[j] | w_term;
        end
      end
      for (int j = 0; j < NGRP; j++) begin
        w_c[j*BLOCK] = w_gc[j];
        for (int i = 1; i < BLOCK; i++) begin
          w_c[j*BLOCK+i] = w_g[j*BLOCK+i-1] | (w_p[j*BLOCK+i-1] & w_c[j*BLOCK+i-1]);
        end
      end
      w_merged              = r_s[k];
      w_merged[OFF +: SEG]  = w_p ^ w_c;
    end

    assign w_acc[k]  = w_merged;
    assign w_cout[k] = w_gc[NGRP];

    if (k == LAST) begin : g_msb
      assign w_cmsb = w_c[SEG-1];
    end
  end

  assign w_ovf = w_cmsb ^ w_cout[LAST];
  assign w_res = (r_sat[LAST] && w_ovf)
               ? (r_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
               : w_acc[LAST];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_S         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      r_a[0]   <= A;
      r_b[0]   <= sub ? ~B : B;
      r_c[0]   <= sub ? ~Cin : Cin;
      r_sat[0] <= sat;
      r_s[0]   <= '0;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_c[k]   <= w_cout[k-1];
        r_sat[k] <= r_sat[k-1];
        r_s[k]   <= w_acc[k-1];
      end
      r_out_valid <= r_vld[LAST];
      r_S         <= w_res;
      r_cout      <= w_cout[LAST];
      r_ovf       <= w_ovf;
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b0;
    end else if (r_out_valid && out_ready && r_ovf) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_addsub.sv
// ============================================================================
// Module   : tb_pipelined_cla_addsub
// Brief    : Table-driven self-checking bench for pipelined_cla_addsub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_cla_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Cin = 1'b0;
  logic        sub = 1'b0;
  logic        sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] S;
  logic        Cout;
  logic        overFlow;
  logic        ovf_sticky;
  logic        clr_sticky = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cout(Cout),
    .overFlow(overFlow), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sb;
    logic        st;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    A   = v.a;
    B   = v.b;
    Cin = v.cin;
    sub = v.sb;
    sat = v.st;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic send_and_check(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_S"}, S, v.s);
    chk1({tag, "_Cout"}, Cout, v.cout);
    chk1({tag, "_overFlow"}, overFlow, v.ovf);
    @(posedge clk);
    #1;
    chk1({tag, "_sticky"}, ovf_sticky, v.ovf);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk1({tag, "_sticky_clr"}, ovf_sticky, 1'b0);
  endtask

  initial begin
    int          lat;
    int          sent;
    int          got;
    logic [31:0] held;
    logic        prev_stall;

    //          a             b             cin   sub   sat   s             cout  ovf
    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{32'h7FFFFFFF, 32'h00000005, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[2]  = '{32'h80000000, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1};
    vecs[3]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 1'b0, 32'h00000006, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h00010001, 1'b0, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000FFFF, 32'hFFFF0000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[10] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1};
    vecs[11] = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[12] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[13] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_S", S, 32'h0);
    chk1("rst_Cout", Cout, 1'b0);
    chk1("rst_overFlow", overFlow, 1'b0);
    chk1("rst_sticky", ovf_sticky, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 14; i++) begin
      send_and_check(vecs[i], $sformatf("v%0d", i));
    end

    // Backpressure: 8 back-to-back beats of (10+k) + (-5), stalled mid-stream.
    sent = 0;
    got = 0;
    held = '0;
    prev_stall = 1'b0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      A   = 32'd10 + 32'(sent);
      B   = 32'hFFFFFFFB;
      Cin = 1'b0;
      sub = 1'b0;
      sat = 1'b0;
      in_valid = (sent < 8);
      #1;
      if (!out_ready && out_valid) begin
        chk1("bp_in_ready", in_ready, 1'b0);
        if (prev_stall) chk("bp_hold", S, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_result%0d", got), S, 32'd5 + 32'(got));
        got++;
      end
      prev_stall = !out_ready && out_valid;
      held = S;
      if (in_valid && in_ready) sent++;
    end
    chk("bp_count", 32'(got), 32'd8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset while two overflowing beats are in flight.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    A = 32'h7FFFFFFF;
    B = 32'h00000002;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk1("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_S", S, 32'h0);
      chk1("mid_rst_sticky", ovf_sticky, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk1("mid_rst_discard", out_valid, 1'b0);
    end
    send_and_check(vecs[9], "post_rst");

    // Clear colliding with an overflowing result being accepted.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk1("coll_out_valid", out_valid, 1'b1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    chk1("coll_set_wins", ovf_sticky, 1'b1);
    @(posedge clk);
    #1;
    chk1("coll_clr_alone", ovf_sticky, 1'b0);
    clr_sticky = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor. It succeeds the fixed 32-bit combinational CLA, adding configurable width, group size and pipeline depth, an add/subtract mode, signed saturation, a sticky overflow flag, and a valid/ready handshake on both sides. It sits between operand-issue logic and any result consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 32: operand/result width; must be a multiple of BLOCK.
- BLOCK, 4: CLA group size in bits; generate/propagate is computed per group.
- STAGES, 2: pipeline register stages, 1..WIDTH/BLOCK; (WIDTH/BLOCK) must be divisible by STAGES.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- A  in  WIDTH  operand A (two's complement).
- B  in  WIDTH  operand B (two's complement).
- Cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: S = A+B+Cin; 1: S = A−B−Cin.
- sat  in  1  1: clamp signed overflow to max/min.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- S  out  WIDTH  result.
- Cout  out  1  raw carry-out of the MSB, unaffected by saturation.
- overFlow  out  1  signed overflow of this result, reported before saturation.
- ovf_sticky  out  1  set by any accepted result with overFlow=1.
- clr_sticky  in  1  clears ovf_sticky.

## Operation
- Effective operands: Beff = sub ? ~B : B; ceff = sub ? ~Cin : Cin. The core computes A + Beff + ceff.
- The datapath is split into STAGES equal segments of WIDTH/STAGES bits, LSB segment first. Each segment is a two-level CLA: BLOCK-bit groups, then a group-level lookahead.
- The carry out of segment k is registered and feeds segment k+1 in the next stage. Operand upper bits and the already-computed lower sum bits are registered alongside the carry. sub and sat travel with the beat.
- overFlow = carry into MSB XOR carry out of MSB.
- Saturation: if sat=1 and overFlow=1, then S = A[MSB] ? {1'b1,{WIDTH-1{0}}} (min) : {1'b0,{WIDTH-1{1}}} (max). Otherwise S is the raw sum modulo 2^WIDTH.
- ovf_sticky: set when out_valid && out_ready && overFlow. Cleared when clr_sticky=1. If both happen in the same cycle, set wins.
- Stall policy is a global enable: adv = !out_valid || out_ready. When adv=0, all stage registers hold. in_ready = adv.
- A beat enters when in_valid && in_ready. Bubbles propagate as valid=0 stages.
- Reset: every stage valid bit clears to 0, so in-flight beats are discarded. S=0, Cout=0, overFlow=0, out_valid=0, ovf_sticky=0. in_ready=1 in the first cycle after reset.

## Timing
- Latency: a beat accepted at edge n appears on out_valid/S at edge n+STAGES, when there is no stall.
- Throughput: one beat per cycle while out_ready=1.
- The output register is the final stage. S, Cout and overFlow are stable while out_valid=1 and out_ready=0.
- out_valid=0 with out_ready=0 still advances the pipe, so bubbles are squeezed out only at the output.
- in_ready is combinational from out_valid/out_ready. There is no combinational path from in_valid to out_valid.
- With STAGES=1 the block behaves as a registered single-cycle CLA: latency 1, with the same handshake.
- rst asserted while stalled takes priority over the hold.

## Test plan
Configuration for all scenarios: WIDTH=32, BLOCK=4, STAGES=2.
- Add overflow: A=0x7FFFFFFF, B=1, Cin=0, sub=0, sat=0 → S=0x80000000, overFlow=1, Cout=0, out_valid 2 cycles after accept; ovf_sticky=1.
- Saturation:
  - A=0x7FFFFFFF, B=5, sat=1 → S=0x7FFFFFFF, overFlow=1.
  - A=0x80000000, B=0xFFFFFFFB, sat=1 → S=0x80000000, overFlow=1, Cout=1.
- Subtract: A=0x80000000, B=1, sub=1, Cin=0 → S=0x7FFFFFFF, overFlow=1, Cout=1. A=5, B=5, sub=1 → S=0, overFlow=0, Cout=1. A=10, B=3, sub=1, Cin=1 → S=6.
- Backpressure: stream 8 beats back-to-back (10+k, −5). Hold out_ready=0 for 3 cycles mid-stream → in_ready=0 for those cycles, output held, no beat lost or duplicated. Results are 5+k in order.
- Reset mid-operation: accept 2 beats, assert rst one cycle before the first would emerge → out_valid stays 0, S=0, ovf_sticky=0. The next beat after reset completes normally.
- Sticky clear collision: clr_sticky=1 in the same cycle an overflowing result is accepted → ovf_sticky=1. clr_sticky=1 alone → ovf_sticky=0 next cycle.
